// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, FSM state and ALU op types for the MIPS cores.
// Also holds the legality check used by the multi-cycle decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_t;

    function automatic logic legal_instr(input logic [31:0] ir);
        logic ok;
        ok = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 GPR file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear. $0 reads as zero and ignores writes.
module mips_mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS32 core sharing one req/ready memory port for fetch and data.
// FETCH/DECODE/EXEC/MEM/WB/HALT control FSM with inline ALU and datapath muxes.
module mips_mc_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned ADDR_W   = 32,
    parameter bit          OVF_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              instr_done,
    output logic              exc,
    output logic [31:0]       pc_dbg
);

    state_t      state, state_next;
    logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] rf_a, rf_b, rf_wdata, alu_b, alu_res, sext, zext, addr_full;
    logic [4:0]  rf_waddr;
    logic        rf_we, exc_q, ovf, trap;
    alu_op_t     alu_op;

    wire [5:0] op     = ir[31:26];
    wire [5:0] funct  = ir[5:0];
    wire       is_rt  = (op == OP_RTYPE);
    wire       is_jr  = is_rt && (funct == F_JR);
    wire       is_beq = (op == OP_BEQ);
    wire       is_lw  = (op == OP_LW);
    wire       is_sw  = (op == OP_SW);
    wire       is_jmp = (op == OP_J) || (op == OP_JAL);
    wire       legal  = legal_instr(ir);
    wire       trap_op = (is_rt && (funct == F_ADD || funct == F_SUB)) || (op == OP_ADDI);

    assign sext = {{16{ir[15]}}, ir[15:0]};
    assign zext = {16'h0, ir[15:0]};

    mips_mc_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ir[25:21]),
        .raddr_b (ir[20:16]),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // jal links in DECODE; every other write happens in WB, so one port suffices
    always_comb begin
        rf_we    = (state == S_WB) || (state == S_DECODE && op == OP_JAL);
        rf_waddr = (state == S_DECODE) ? 5'd31 : (is_rt ? ir[15:11] : ir[20:16]);
        rf_wdata = (state == S_DECODE) ? pc : (is_lw ? mdr : alu_out);
    end

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = sext;
        case (op)
            OP_RTYPE: begin
                alu_b = b_reg;
                case (funct)
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_SLT:         alu_op = ALU_SLT;
                    default:       alu_op = ALU_ADD;
                endcase
            end
            OP_ANDI: begin alu_op = ALU_AND; alu_b = zext; end
            OP_ORI:  begin alu_op = ALU_OR;  alu_b = zext; end
            OP_LUI:  alu_op = ALU_LUI;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a_reg + alu_b;
            ALU_SUB: alu_res = a_reg - alu_b;
            ALU_AND: alu_res = a_reg & alu_b;
            ALU_OR:  alu_res = a_reg | alu_b;
            ALU_SLT: alu_res = {31'b0, $signed(a_reg) < $signed(alu_b)};
            ALU_LUI: alu_res = {ir[15:0], 16'h0};
            default: alu_res = '0;
        endcase
        ovf = (alu_op == ALU_SUB) ? ((a_reg[31] != alu_b[31]) && (alu_res[31] != a_reg[31]))
                                  : ((a_reg[31] == alu_b[31]) && (alu_res[31] != a_reg[31]));
        trap = OVF_TRAP && trap_op && ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = !legal ? S_HALT : (is_jmp ? S_FETCH : S_EXEC);
            S_EXEC: begin
                if (is_beq || is_jr)     state_next = S_FETCH;
                else if (is_lw || is_sw) state_next = S_MEM;
                else if (trap)           state_next = S_HALT;
                else                     state_next = S_WB;
            end
            S_MEM:    if (mem_ready) state_next = is_sw ? S_FETCH : S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    // rst gates the request so an access in flight is dropped in the reset cycle itself
    always_comb begin
        mem_req    = rst && (state == S_FETCH || state == S_MEM);
        mem_we     = rst && (state == S_MEM) && is_sw;
        addr_full  = (state == S_MEM) ? {alu_out[31:2], 2'b00} : {pc[31:2], 2'b00};
        mem_addr   = addr_full[ADDR_W-1:0];
        mem_wdata  = b_reg;
        instr_done = rst && ((state == S_DECODE && is_jmp) ||
                             (state == S_EXEC && (is_beq || is_jr)) ||
                             (state == S_MEM && is_sw && mem_ready) ||
                             (state == S_WB));
        exc        = exc_q;
        pc_dbg     = pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            exc_q   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a_reg <= rf_a;
                    b_reg <= rf_b;
                    if (!legal)      exc_q <= 1'b1;
                    else if (is_jmp) pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                S_EXEC: begin
                    if (is_beq) begin
                        if (a_reg == b_reg) pc <= pc + {sext[29:0], 2'b00};
                    end else if (is_jr) begin
                        pc <= a_reg;
                    end else if (trap) begin
                        exc_q <= 1'b1;
                    end else begin
                        alu_out <= alu_res;
                    end
                end
                S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: table-driven ALU vectors plus directed
// multi-cycle sequences (wait states, branches, jal, overflow trap, illegal op, reset).
module tb_mips_mc_core;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req0, we0, rdy0, done0, exc0;
    logic [31:0] addr0, wd0, rd0, pc0;
    logic        req1, we1, rdy1, done1, exc1;
    logic [31:0] addr1, wd1, rd1, pc1;

    logic [31:0] rom  [1024];
    logic [31:0] ram0 [1024];
    logic [31:0] ram1 [1024];
    int unsigned wait_n = 0;
    int unsigned wcnt0  = 0;
    logic        clr_ram = 1'b0;

    mips_mc_core #(.RESET_PC(32'h0000_3000), .ADDR_W(32), .OVF_TRAP(1'b1)) dut0 (
        .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wd0), .mem_rdata(rd0), .mem_ready(rdy0), .instr_done(done0),
        .exc(exc0), .pc_dbg(pc0));

    mips_mc_core #(.RESET_PC(32'h0000_3000), .ADDR_W(32), .OVF_TRAP(1'b0)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_rdata(rd1), .mem_ready(rdy1), .instr_done(done1),
        .exc(exc1), .pc_dbg(pc1));

    // Program ROM at 0x3000..0x3FFC, data RAM below; dut1 always sees zero-wait memory
    assign rd0  = (addr0[13:12] == 2'b11) ? rom[addr0[11:2]] : ram0[addr0[11:2]];
    assign rd1  = (addr1[13:12] == 2'b11) ? rom[addr1[11:2]] : ram1[addr1[11:2]];
    assign rdy0 = req0 && (wcnt0 == wait_n);
    assign rdy1 = req1;

    always @(posedge clk) begin
        if (!req0 || rdy0) wcnt0 <= 0;
        else               wcnt0 <= wcnt0 + 1;
        if (clr_ram) begin
            for (int i = 0; i < 1024; i++) begin
                ram0[i] <= '0;
                ram1[i] <= '0;
            end
        end else begin
            if (req0 && rdy0 && we0) ram0[addr0[11:2]] <= wd0;
            if (req1 && rdy1 && we1) ram1[addr1[11:2]] <= wd1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {OP_RTYPE, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    localparam logic [31:0] SPIN = 32'h1000_FFFF;  // beq $0,$0,-1

    // Handshake-stability monitor state, updated once per sampled cycle
    logic        p_wait = 1'b0, p_req, p_we;
    logic [31:0] p_addr, p_wd;
    int          stab_err = 0;
    int          wait_seen = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (p_wait && (req0 !== p_req || we0 !== p_we || addr0 !== p_addr || wd0 !== p_wd))
            stab_err++;
        if (req0 && !rdy0) wait_seen++;
        p_wait = req0 && !rdy0;
        p_req  = req0;
        p_we   = we0;
        p_addr = addr0;
        p_wd   = wd0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = SPIN;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr_ram = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        clr_ram = 1'b0;
        rst = 1'b1;
        cyc = 0;
        p_wait = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] instr;
        int          dest;
        logic [31:0] exp;
        logic        exp_exc;
    } vec_t;

    vec_t vecs[15];

    int t[8];
    int nd;
    int nreq;
    logic [31:0] cap_pc, cap_addr;
    logic        cap_req, found;

    initial begin
        vecs[0]  = '{"addu",     32'h7FFF_FFFF, 32'h0000_0001, enc_r(1, 2, 3, F_ADDU), 3, 32'h8000_0000, 1'b0};
        vecs[1]  = '{"subu",     32'h0000_0005, 32'h0000_0007, enc_r(1, 2, 3, F_SUBU), 3, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{"add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, enc_r(1, 2, 3, F_ADD),  3, 32'h0000_0000, 1'b1};
        vecs[3]  = '{"sub_ovf",  32'h8000_0000, 32'h0000_0001, enc_r(1, 2, 3, F_SUB),  3, 32'h0000_0000, 1'b1};
        vecs[4]  = '{"and",      32'hF0F0_FF00, 32'h0FF0_F0F0, enc_r(1, 2, 3, F_AND),  3, 32'h00F0_F000, 1'b0};
        vecs[5]  = '{"or",       32'hF0F0_FF00, 32'h0FF0_F0F0, enc_r(1, 2, 3, F_OR),   3, 32'hFFF0_FFF0, 1'b0};
        vecs[6]  = '{"slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, enc_r(1, 2, 3, F_SLT),  3, 32'h0000_0001, 1'b0};
        vecs[7]  = '{"slt_pos",  32'h0000_0001, 32'hFFFF_FFFF, enc_r(1, 2, 3, F_SLT),  3, 32'h0000_0000, 1'b0};
        vecs[8]  = '{"addiu",    32'h0000_0005, 32'h0,         enc_i(OP_ADDIU, 1, 3, 16'hFFFF), 3, 32'h0000_0004, 1'b0};
        vecs[9]  = '{"addi_ovf", 32'h7FFF_FFFF, 32'h0,         enc_i(OP_ADDI,  1, 3, 16'h0001), 3, 32'h0000_0000, 1'b1};
        vecs[10] = '{"andi",     32'hFFFF_1234, 32'h0,         enc_i(OP_ANDI,  1, 3, 16'hFFFF), 3, 32'h0000_1234, 1'b0};
        vecs[11] = '{"ori",      32'h0001_0000, 32'h0,         enc_i(OP_ORI,   1, 3, 16'h8000), 3, 32'h0001_8000, 1'b0};
        vecs[12] = '{"lui",      32'h0,         32'h0,         enc_i(OP_LUI,   0, 3, 16'hABCD), 3, 32'hABCD_0000, 1'b0};
        vecs[13] = '{"add_r0",   32'h0000_0001, 32'h0000_0002, enc_r(1, 2, 0, F_ADD),  0, 32'h0000_0000, 1'b0};
        vecs[14] = '{"addi_neg", 32'h0000_0005, 32'h0,         enc_i(OP_ADDI,  1, 3, 16'hFFFE), 3, 32'h0000_0003, 1'b0};

        clear_rom();

        // Reset state, sampled while rst is still low
        rst = 1'b0;
        clr_ram = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", {31'b0, req0}, 32'h0);
        check("rst_mem_we", {31'b0, we0}, 32'h0);
        check("rst_instr_done", {31'b0, done0}, 32'h0);
        check("rst_exc", {31'b0, exc0}, 32'h0);
        check("rst_pc", pc0, 32'h0000_3000);

        // Table-driven single-instruction ALU vectors
        wait_n = 0;
        foreach (vecs[k]) begin
            clear_rom();
            rom[0] = enc_i(OP_LUI, 0, 1, vecs[k].a[31:16]);
            rom[1] = enc_i(OP_ORI, 1, 1, vecs[k].a[15:0]);
            rom[2] = enc_i(OP_LUI, 0, 2, vecs[k].b[31:16]);
            rom[3] = enc_i(OP_ORI, 2, 2, vecs[k].b[15:0]);
            rom[4] = vecs[k].instr;
            do_reset();
            nd = 0;
            while (nd < 5 && !exc0 && cyc < 200) begin
                tick();
                if (done0) nd++;
            end
            if (cyc >= 200) check({vecs[k].name, "_timeout"}, cyc, 0);
            tick();
            check({vecs[k].name, "_val"}, dut0.u_regfile.regs[vecs[k].dest], vecs[k].exp);
            check({vecs[k].name, "_exc"}, {31'b0, exc0}, {31'b0, vecs[k].exp_exc});
        end

        // ori/addu with zero-wait memory: retire timing and pc
        clear_rom();
        rom[0] = enc_i(OP_ORI, 0, 1, 16'h1234);
        rom[1] = enc_r(1, 1, 2, F_ADDU);
        do_reset();
        nd = 0;
        t = '{default: 0};
        cap_pc = '0;
        repeat (10) begin
            tick();
            if (done0 && nd < 8) begin t[nd] = cyc; nd++; end
            if (cyc == 8) cap_pc = pc0;
        end
        check("t1_done0", t[0], 4);
        check("t1_done1", t[1], 8);
        check("t1_pc", cap_pc, 32'h0000_3008);
        check("t1_r2", dut0.u_regfile.regs[2], 32'h0000_2468);

        // sw/lw with 3 wait cycles on every access
        wait_n = 3;
        clear_rom();
        rom[0] = enc_i(OP_ORI, 0, 1, 16'h1234);
        rom[1] = enc_r(1, 1, 2, F_ADDU);
        rom[2] = enc_i(OP_SW, 0, 2, 16'h0000);
        rom[3] = enc_i(OP_LW, 0, 3, 16'h0000);
        do_reset();
        stab_err = 0;
        wait_seen = 0;
        nd = 0;
        t = '{default: 0};
        while (nd < 4 && cyc < 200) begin
            tick();
            if (done0) begin t[nd] = cyc; nd++; end
        end
        tick();
        check("t2_ori_done", t[0], 7);
        check("t2_sw_done", t[2], 24);
        check("t2_lw_latency", t[3] - t[2], 11);
        check("t2_stable", stab_err, 0);
        check("t2_waits_seen", {31'b0, wait_seen > 0}, 32'h1);
        check("t2_ram0", ram0[0], 32'h0000_2468);
        check("t2_r3", dut0.u_regfile.regs[3], 32'h0000_2468);

        // beq loop: back to its own address every 3 cycles
        wait_n = 0;
        clear_rom();
        do_reset();
        nd = 0;
        t = '{default: 0};
        cap_pc = '0;
        cap_addr = '0;
        cap_req = 1'b0;
        repeat (10) begin
            tick();
            if (done0 && nd < 8) begin t[nd] = cyc; nd++; end
            if (cyc == 4) begin cap_pc = pc0; cap_addr = addr0; cap_req = req0; end
        end
        check("t3_beq_done", t[0], 3);
        check("t3_beq_period", t[1] - t[0], 3);
        check("t3_beq_pc", cap_pc, 32'h0000_3000);
        check("t3_beq_fetch", cap_addr, 32'h0000_3000);
        check("t3_beq_req", {31'b0, cap_req}, 32'h1);

        // jal at 0x3008 to 0x3100
        clear_rom();
        rom[0] = enc_i(OP_ORI, 0, 0, 16'h0000);
        rom[1] = enc_i(OP_ORI, 0, 0, 16'h0000);
        rom[2] = {OP_JAL, 26'h0000C40};
        do_reset();
        nd = 0;
        t = '{default: 0};
        cap_pc = '0;
        repeat (14) begin
            tick();
            if (done0 && nd < 8) begin t[nd] = cyc; nd++; end
            if (cyc == 11) cap_pc = addr0;
        end
        check("t3_jal_latency", t[2] - t[1], 2);
        check("t3_jal_target", cap_pc, 32'h0000_3100);
        check("t3_jal_r31", dut0.u_regfile.regs[31], 32'h0000_300C);

        // add overflow: trapping core halts, wrapping core writes
        clear_rom();
        rom[0] = enc_i(OP_LUI, 0, 1, 16'h7FFF);
        rom[1] = enc_i(OP_ORI, 1, 1, 16'hFFFF);
        rom[2] = enc_r(1, 1, 2, F_ADD);
        do_reset();
        nd = 0;
        nreq = 0;
        repeat (40) begin
            tick();
            if (done0) nd++;
            if (exc0 && req0) nreq++;
        end
        check("t4_exc", {31'b0, exc0}, 32'h1);
        check("t4_r2", dut0.u_regfile.regs[2], 32'h0);
        check("t4_req_after", nreq, 0);
        check("t4_retired", nd, 2);
        check("t4_pc", pc0, 32'h0000_300C);
        check("t4_wrap_r2", dut1.u_regfile.regs[2], 32'hFFFF_FFFE);
        check("t4_wrap_exc", {31'b0, exc1}, 32'h0);

        // Illegal opcode 0x3F
        clear_rom();
        rom[0] = 32'hFC00_0000;
        do_reset();
        tick();
        tick();
        check("t5_exc_decode", {31'b0, exc0}, 32'h0);
        tick();
        check("t5_exc_after", {31'b0, exc0}, 32'h1);
        nreq = 0;
        repeat (10) begin
            tick();
            if (req0) nreq++;
        end
        check("t5_no_req", nreq, 0);

        // Reset asserted while a store waits in MEM
        wait_n = 3;
        clear_rom();
        rom[0] = enc_i(OP_ORI, 0, 1, 16'h0005);
        rom[1] = enc_i(OP_SW, 0, 1, 16'h0004);
        do_reset();
        found = 1'b0;
        while (!found && cyc < 100) begin
            tick();
            if (req0 && we0 && !rdy0) found = 1'b1;
        end
        check("t6_found_mem", {31'b0, found}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_req_low", {31'b0, req0}, 32'h0);
        check("t6_pc", pc0, 32'h0000_3000);
        check("t6_r1", dut0.u_regfile.regs[1], 32'h0);
        check("t6_ram_untouched", ram0[1], 32'h0);
        rst = 1'b1;
        cyc = 0;
        p_wait = 1'b0;
        tick();
        check("t6_refetch_req", {31'b0, req0}, 32'h1);
        check("t6_refetch_addr", addr0, 32'h0000_3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
